// File: rtl/acm_scrub_if.sv
// Bundles the pipeline write-back, observed read ports, scrub read port and
// register-file write port of the ECC scrubber.
interface acm_scrub_if #(
  parameter int unsigned W  = 32,
  parameter int unsigned N  = 32,
  parameter int unsigned RP = 2
);
  localparam int unsigned AW = $clog2(N);

  logic                   s_wb_we_i;
  logic [AW-1:0]          s_wb_add_i;
  logic [W-1:0]           s_wb_val_i;
  logic [RP-1:0]          s_rp_en_i;
  logic [RP-1:0][AW-1:0]  s_rp_add_i;
  logic [RP-1:0][W-1:0]   s_rp_val_i;
  logic [AW-1:0]          s_scr_add_o;
  logic [W-1:0]           s_scr_val_i;
  logic                   s_ecc_en_i;
  logic [15:0]            s_scrub_period_i;
  logic                   s_we_o;
  logic [AW-1:0]          s_add_o;
  logic [W-1:0]           s_val_o;
  logic                   s_busy_o;
  logic [15:0]            s_ce_cnt_o;
  logic [15:0]            s_ue_cnt_o;
  logic                   s_ue_o;
  logic [AW-1:0]          s_ue_add_o;

  modport slave (
    input  s_wb_we_i, s_wb_add_i, s_wb_val_i,
    input  s_rp_en_i, s_rp_add_i, s_rp_val_i,
    input  s_scr_val_i, s_ecc_en_i, s_scrub_period_i,
    output s_scr_add_o, s_we_o, s_add_o, s_val_o, s_busy_o,
    output s_ce_cnt_o, s_ue_cnt_o, s_ue_o, s_ue_add_o
  );

  modport master (
    output s_wb_we_i, s_wb_add_i, s_wb_val_i,
    output s_rp_en_i, s_rp_add_i, s_rp_val_i,
    output s_scr_val_i, s_ecc_en_i, s_scrub_period_i,
    input  s_scr_add_o, s_we_o, s_add_o, s_val_o, s_busy_o,
    input  s_ce_cnt_o, s_ue_cnt_o, s_ue_o, s_ue_add_o
  );
endinterface

// File: rtl/acm_scrub.sv
// SECDED shadow-checksum scrubber for a register file: watches read ports and a
// periodic scrub read, repairs single-bit errors and flags double-bit errors.
module acm_scrub #(
  parameter int unsigned W        = 32,
  parameter int unsigned N        = 32,
  parameter int unsigned RP       = 2,
  parameter int unsigned CW       = 7,
  parameter int unsigned ZERO_REG = 1
) (
  input logic        s_clk_i,
  input logic        s_reset_i,
  acm_scrub_if.slave bus
);
  localparam int unsigned AW = $clog2(N);
  localparam int unsigned HW = CW - 1;
  localparam int unsigned IW = $clog2(W);

  typedef enum logic [1:0] {IDLE, CHECK, CORRECT} state_t;

  // Hamming part: XOR of codeword positions of all set data bits (positions skip powers of two).
  function automatic logic [HW-1:0] ham(input logic [W-1:0] d);
    int unsigned hv;
    int unsigned k;
    hv = 0;
    k  = 0;
    for (int unsigned p = 1; p < W + CW; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (k < W && d[IW'(k)]) hv = hv ^ p;
        k = k + 1;
      end
    end
    return HW'(hv);
  endfunction

  function automatic logic [CW-1:0] encode(input logic [W-1:0] d);
    logic [HW-1:0] h;
    h = ham(d);
    return {(^d) ^ (^h), h};
  endfunction

  function automatic logic [W-1:0] fix(input logic [W-1:0] d, input logic [HW-1:0] s);
    logic [W-1:0] r;
    int unsigned  k;
    r = d;
    k = 0;
    for (int unsigned p = 1; p < W + CW; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (k < W && p == 32'(s)) r[IW'(k)] = ~d[IW'(k)];
        k = k + 1;
      end
    end
    return r;
  endfunction

  function automatic logic has_err(input logic [W-1:0] v, input logic [CW-1:0] c);
    return ((ham(v) ^ c[HW-1:0]) != '0) || ((^v) ^ (^c));
  endfunction

  state_t            state_q, state_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [W-1:0]      val_q, val_d;
  logic [CW-1:0]     chk_q [N];
  logic [15:0]       timer_q;
  logic [AW-1:0]     ptr_q;
  logic [15:0]       ce_q, ue_q;

  logic              scr_fire;
  logic              cand;
  logic [AW-1:0]     cand_add;
  logic [W-1:0]      cand_val;
  logic              wb_hit;
  logic [CW-1:0]     stored;
  logic [HW-1:0]     syn;
  logic              par;
  logic              ue_c, fix_c;
  logic              we_c;
  logic [AW-1:0]     add_c;
  logic [W-1:0]      val_c;

  function automatic logic eligible(input logic en, input logic [AW-1:0] a,
                                    input logic [W-1:0] v, input logic [CW-1:0] c,
                                    input logic wbe, input logic [AW-1:0] wba);
    return en && !(ZERO_REG != 0 && a == '0) && has_err(v, c) && !(wbe && wba == a);
  endfunction

  assign scr_fire = (state_q == IDLE) && (bus.s_scrub_period_i != 16'd0) &&
                    (timer_q == bus.s_scrub_period_i - 16'd1);

  // Lowest-index read port wins; the scrub read only fills in when no port qualifies.
  always_comb begin
    cand     = 1'b0;
    cand_add = '0;
    cand_val = '0;
    for (int unsigned p = 0; p < RP; p++) begin
      if (!cand && eligible(bus.s_rp_en_i[p], bus.s_rp_add_i[p], bus.s_rp_val_i[p],
                            chk_q[bus.s_rp_add_i[p]], bus.s_wb_we_i, bus.s_wb_add_i)) begin
        cand     = 1'b1;
        cand_add = bus.s_rp_add_i[p];
        cand_val = bus.s_rp_val_i[p];
      end
    end
    if (!cand && eligible(scr_fire, ptr_q, bus.s_scr_val_i, chk_q[ptr_q],
                          bus.s_wb_we_i, bus.s_wb_add_i)) begin
      cand     = 1'b1;
      cand_add = ptr_q;
      cand_val = bus.s_scr_val_i;
    end
  end

  assign wb_hit = bus.s_wb_we_i && (bus.s_wb_add_i == addr_q);
  assign stored = chk_q[addr_q];
  assign syn    = ham(val_q) ^ stored[HW-1:0];
  assign par    = (^val_q) ^ (^stored);

  always_ff @(posedge s_clk_i or posedge s_reset_i) begin
    if (s_reset_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      val_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      val_q   <= val_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    val_d   = val_q;
    ue_c    = 1'b0;
    fix_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.s_ecc_en_i && cand) begin
          state_d = CHECK;
          addr_d  = cand_add;
          val_d   = cand_val;
        end
      end
      CHECK: begin
        if (!bus.s_ecc_en_i || wb_hit) begin
          state_d = IDLE;
        end else if (syn == '0 && !par) begin
          state_d = IDLE;
        end else if (par) begin
          state_d = CORRECT;
          val_d   = fix(val_q, syn);
        end else begin
          state_d = IDLE;
          ue_c    = 1'b1;
        end
      end
      CORRECT: begin
        if (!bus.s_ecc_en_i || wb_hit) begin
          state_d = IDLE;
        end else if (!bus.s_wb_we_i) begin
          state_d = IDLE;
          fix_c   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pipeline write-back always owns the write port; a pending repair waits behind it.
  assign we_c  = !s_reset_i && (bus.s_wb_we_i || fix_c);
  assign add_c = bus.s_wb_we_i ? bus.s_wb_add_i : addr_q;
  assign val_c = bus.s_wb_we_i ? bus.s_wb_val_i : val_q;

  always_ff @(posedge s_clk_i or posedge s_reset_i) begin
    if (s_reset_i) begin
      for (int unsigned i = 0; i < N; i++) chk_q[i] <= '0;
    end else if (we_c) begin
      chk_q[add_c] <= encode(val_c);
    end
  end

  always_ff @(posedge s_clk_i or posedge s_reset_i) begin
    if (s_reset_i) begin
      timer_q <= '0;
      ptr_q   <= AW'(ZERO_REG);
    end else if (state_q == IDLE && bus.s_scrub_period_i != 16'd0) begin
      if (scr_fire) begin
        timer_q <= '0;
        ptr_q   <= (ptr_q == AW'(N - 1)) ? AW'(ZERO_REG) : ptr_q + AW'(1);
      end else begin
        timer_q <= timer_q + 16'd1;
      end
    end
  end

  always_ff @(posedge s_clk_i or posedge s_reset_i) begin
    if (s_reset_i) begin
      ce_q <= '0;
      ue_q <= '0;
    end else begin
      if (fix_c && ce_q != 16'hFFFF) ce_q <= ce_q + 16'd1;
      if (ue_c && ue_q != 16'hFFFF) ue_q <= ue_q + 16'd1;
    end
  end

  assign bus.s_scr_add_o = ptr_q;
  assign bus.s_we_o      = we_c;
  assign bus.s_add_o     = add_c;
  assign bus.s_val_o     = val_c;
  assign bus.s_busy_o    = (state_q != IDLE);
  assign bus.s_ce_cnt_o  = ce_q;
  assign bus.s_ue_cnt_o  = ue_q;
  assign bus.s_ue_o      = ue_c;
  assign bus.s_ue_add_o  = ue_c ? addr_q : '0;
endmodule
